// File: rtl/serial_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_gen_if
//  Description : Control and status bundle for serial_pattern_gen.
//                The master side (switches / stimulus) drives start, stop,
//                pattern, len and repeat_en. The slave side (the generator)
//                returns the serial stream and its status flags.
//  Ports       :
//    start      master->slave  start request (level)
//    stop       master->slave  abort request (level)
//    pattern    master->slave  WIDTH-bit pattern, sent MSB (pattern[L-1]) first
//    len        master->slave  pattern length in bits; 0 or >WIDTH means WIDTH
//    repeat_en  master->slave  loop the pattern until stop
//    sout       slave->master  serial bit stream
//    sout_vld   slave->master  pulse on the first cycle of each bit
//    bit_idx    slave->master  pattern index of the bit on sout
//    busy       slave->master  high while a run is in progress
//    done       slave->master  one-cycle pulse when a single-shot run ends
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] pattern;
  logic [LENW-1:0]  len;
  logic             repeat_en;
  logic             sout;
  logic             sout_vld;
  logic [LENW-1:0]  bit_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pattern, len, repeat_en,
    input  sout, sout_vld, bit_idx, busy, done
  );

  modport slave (
    input  start, stop, pattern, len, repeat_en,
    output sout, sout_vld, bit_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_gen
//  Description : Latches a parallel bit pattern on start and shifts it out
//                MSB-first on a single serial line, holding each bit for DIV
//                clocks. Supports single-shot or continuous repeat, abort via
//                stop, and busy/done status. All outputs are registered.
//  Ports       :
//    clk   in   system clock, rising edge
//    clr   in   asynchronous active-high reset
//    pg    slave modport of serial_pattern_gen_if (see interface header)
//  Parameters  :
//    WIDTH  maximum pattern length in bits (2..16)
//    DIV    clocks each bit is held on sout (>=1)
//    LENW   width of len / bit_idx; 2**LENW must exceed WIDTH
//  Revision    : 1.0  initial release
// ============================================================================
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int LENW  = 4
) (
  input  wire logic             clk,
  input  wire logic             clr,
  serial_pattern_gen_if.slave   pg
);

  // Divider is at least one bit wide; with DIV=1 it never leaves zero and
  // synthesis folds it to a constant.
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIVW-1:0]  c_DIV_LAST = DIVW'(DIV - 1);
  localparam logic [DIVW-1:0]  c_DIV_ONE  = DIVW'(1);
  localparam logic [LENW-1:0]  c_IDX_ONE  = LENW'(1);
  localparam logic [LENW-1:0]  c_LEN_MAX  = LENW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pat_q,   pat_d;    // shadow copy of the pattern
  logic [LENW-1:0]   len_q,   len_d;    // shadow effective length L
  logic              rep_q,   rep_d;    // shadow repeat enable
  logic [DIVW-1:0]   div_q,   div_d;
  logic [LENW-1:0]   idx_q,   idx_d;
  logic              sout_q,  sout_d;
  logic              vld_q,   vld_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  // Effective length of the incoming request: 0 or anything beyond WIDTH
  // selects the full pattern width.
  logic [LENW-1:0]   w_len_eff;
  logic [LENW-1:0]   w_start_idx;
  logic [WIDTH-1:0]  w_start_shift;

  // Index and bit presented at the next bit boundary while running. Once the
  // last bit (index 0) has been held, the index wraps back to L-1, which is
  // only used when the run repeats.
  logic [LENW-1:0]   w_next_idx;
  logic [WIDTH-1:0]  w_next_shift;
  logic              w_div_last;

  assign w_len_eff     = ((pg.len == '0) || (pg.len > c_LEN_MAX)) ? c_LEN_MAX : pg.len;
  assign w_start_idx   = w_len_eff - c_IDX_ONE;
  assign w_start_shift = pg.pattern >> w_start_idx;

  assign w_next_idx    = (idx_q != '0) ? (idx_q - c_IDX_ONE) : (len_q - c_IDX_ONE);
  assign w_next_shift  = pat_q >> w_next_idx;
  assign w_div_last    = (div_q == c_DIV_LAST);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    div_d   = div_q;
    idx_d   = idx_q;
    sout_d  = 1'b0;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // stop outranks start so a held abort keeps the block parked.
        if (!pg.stop && pg.start) begin
          state_d = ST_RUN;
          pat_d   = pg.pattern;
          len_d   = w_len_eff;
          rep_d   = pg.repeat_en;
          div_d   = '0;
          idx_d   = w_start_idx;
          sout_d  = w_start_shift[0];
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (pg.stop) begin
          state_d = ST_IDLE;
          div_d   = '0;
          idx_d   = '0;
        end else if (!w_div_last) begin
          // Hold the current bit for the rest of its DIV-cycle slot.
          div_d  = div_q + c_DIV_ONE;
          sout_d = sout_q;
          busy_d = 1'b1;
        end else if ((idx_q != '0) || rep_q) begin
          // Next bit, or seamless wrap to pattern[L-1] when repeating.
          div_d  = '0;
          idx_d  = w_next_idx;
          sout_d = w_next_shift[0];
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else begin
          state_d = ST_DONE;
          div_d   = '0;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        // Single status cycle; start is deliberately not sampled here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign pg.sout     = sout_q;
  assign pg.sout_vld = vld_q;
  assign pg.bit_idx  = idx_q;
  assign pg.busy     = busy_q;
  assign pg.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_pattern_gen
//  Description : Directed bench for serial_pattern_gen. Two instances are
//                used: one with DIV=1 and one with DIV=4. Each cycle the
//                observed tuple {sout, sout_vld, busy, done, bit_idx} is
//                compared with a hand-derived expected tuple.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_pattern_gen;

  logic clk;
  logic clr;

  int vectors;
  int miscompares;

  serial_pattern_gen_if #(.WIDTH(8), .LENW(4)) if1 ();
  serial_pattern_gen_if #(.WIDTH(8), .LENW(4)) if4 ();

  serial_pattern_gen #(.WIDTH(8), .DIV(1), .LENW(4)) dut1 (
    .clk (clk),
    .clr (clr),
    .pg  (if1.slave)
  );

  serial_pattern_gen #(.WIDTH(8), .DIV(4), .LENW(4)) dut4 (
    .clk (clk),
    .clr (clr),
    .pg  (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {sout, sout_vld, busy, done, bit_idx[3:0]}
  function automatic logic [7:0] obs1();
    return {if1.sout, if1.sout_vld, if1.busy, if1.done, if1.bit_idx};
  endfunction

  function automatic logic [7:0] obs4();
    return {if4.sout, if4.sout_vld, if4.busy, if4.done, if4.bit_idx};
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] o;
    clr = 1'b1;
    tick();
    tick();
    o = obs1();
    vectors++;
    if (o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_div1: got %h expected %h", o, 8'h00);
    end
    o = obs4();
    vectors++;
    if (o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_div4: got %h expected %h", o, 8'h00);
    end
    clr = 1'b0;
    tick();
    o = obs1();
    vectors++;
    if (o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", o, 8'h00);
    end
  endtask

  // pattern 0x0D, len 4 -> 1,1,0,1 then done
  task automatic test_single_shot();
    logic [7:0] exp [6] = '{8'hE3, 8'hE2, 8'h61, 8'hE0, 8'h10, 8'h00};
    logic [7:0] o;
    if1.pattern = 8'h0D; if1.len = 4'd4; if1.repeat_en = 1'b0;
    if1.start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if1.start = 1'b0;
      o = obs1();
      vectors++;
      if (o !== exp[c]) begin
        miscompares++;
        $display("FAIL single_shot cyc k+%0d: got %h expected %h", c + 1, o, exp[c]);
      end
    end
  endtask

  // DIV=4, pattern 0x05, len 3 -> 1,0,1 each held 4 cycles, done at k+13
  task automatic test_divider();
    logic [0:2] seq = 3'b101;
    logic [7:0] e;
    logic [7:0] o;
    if4.pattern = 8'h05; if4.len = 4'd3; if4.repeat_en = 1'b0;
    if4.start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int d = 0; d < 4; d++) begin
        tick();
        if4.start = 1'b0;
        e = {seq[b], (d == 0), 1'b1, 1'b0, 4'(2 - b)};
        o = obs4();
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL divider bit %0d hold %0d: got %h expected %h", b, d, o, e);
        end
      end
    end
    tick();
    o = obs4();
    vectors++;
    if (o !== 8'h10) begin
      miscompares++;
      $display("FAIL divider_done: got %h expected %h", o, 8'h10);
    end
    tick();
    o = obs4();
    vectors++;
    if (o !== 8'h00) begin
      miscompares++;
      $display("FAIL divider_idle: got %h expected %h", o, 8'h00);
    end
  endtask

  // repeat 101 with no gap, stop during k+5, no done afterwards
  task automatic test_repeat_stop();
    logic [7:0] exp [5] = '{8'hE2, 8'h61, 8'hE0, 8'hE2, 8'h61};
    logic [7:0] o;
    if1.pattern = 8'h05; if1.len = 4'd3; if1.repeat_en = 1'b1;
    if1.start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if1.start = 1'b0;
      o = obs1();
      vectors++;
      if (o !== exp[c]) begin
        miscompares++;
        $display("FAIL repeat cyc k+%0d: got %h expected %h", c + 1, o, exp[c]);
      end
    end
    if1.stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if1.stop = 1'b0;
      o = obs1();
      vectors++;
      if (o !== 8'h00) begin
        miscompares++;
        $display("FAIL repeat_stop cyc %0d: got %h expected %h", c, o, 8'h00);
      end
    end
    if1.repeat_en = 1'b0;
  endtask

  // len 0 and len 9 both mean 8 bits of 0xA5
  task automatic test_len_default();
    logic [0:7] seq = 8'b10100101;
    logic [3:0] lens [2] = '{4'd0, 4'd9};
    logic [7:0] e;
    logic [7:0] o;
    for (int t = 0; t < 2; t++) begin
      if1.pattern = 8'hA5; if1.len = lens[t];
      if1.start = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        if1.start = 1'b0;
        e = {seq[i], 1'b1, 1'b1, 1'b0, 4'(7 - i)};
        o = obs1();
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL len_default len=%0d bit %0d: got %h expected %h", lens[t], i, o, e);
        end
      end
      tick();
      o = obs1();
      vectors++;
      if (o !== 8'h10) begin
        miscompares++;
        $display("FAIL len_default_done len=%0d: got %h expected %h", lens[t], o, 8'h10);
      end
      tick();
    end
  endtask

  // async clear mid-run, then a run immune to mid-run start/pattern changes
  task automatic test_clr_midrun();
    logic [0:7] seq_a = 8'b10100101;
    logic [0:7] seq_b = 8'b10010110;
    logic [7:0] e;
    logic [7:0] o;
    if1.pattern = 8'hA5; if1.len = 4'd8;
    if1.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if1.start = 1'b0;
      e = {seq_a[i], 1'b1, 1'b1, 1'b0, 4'(7 - i)};
      o = obs1();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL clr_pre bit %0d: got %h expected %h", i, o, e);
      end
    end
    #2 clr = 1'b1;
    #1;
    o = obs1();
    vectors++;
    if (o !== 8'h00) begin
      miscompares++;
      $display("FAIL clr_async: got %h expected %h", o, 8'h00);
    end
    clr = 1'b0;
    tick();
    o = obs1();
    vectors++;
    if (o !== 8'h00) begin
      miscompares++;
      $display("FAIL clr_idle: got %h expected %h", o, 8'h00);
    end
    if1.pattern = 8'h96; if1.len = 4'd8;
    if1.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        if1.pattern = 8'hFF; if1.len = 4'd3; if1.repeat_en = 1'b1;
      end
      if (i == 2) if1.start = 1'b0;
      e = {seq_b[i], 1'b1, 1'b1, 1'b0, 4'(7 - i)};
      o = obs1();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL clr_restart bit %0d: got %h expected %h", i, o, e);
      end
    end
    tick();
    o = obs1();
    vectors++;
    if (o !== 8'h10) begin
      miscompares++;
      $display("FAIL clr_restart_done: got %h expected %h", o, 8'h10);
    end
    if1.repeat_en = 1'b0;
    tick();
  endtask

  // start+stop together stays idle
  task automatic test_start_stop_priority();
    logic [7:0] o;
    if1.pattern = 8'hFF; if1.len = 4'd4;
    if1.start = 1'b1; if1.stop = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      o = obs1();
      vectors++;
      if (o !== 8'h00) begin
        miscompares++;
        $display("FAIL start_stop cyc %0d: got %h expected %h", c, o, 8'h00);
      end
    end
    if1.start = 1'b0; if1.stop = 1'b0;
    tick();
  endtask

  // start held high across DONE: the new run starts one cycle after done
  task automatic test_back_to_back();
    logic [7:0] exp [7] = '{8'h61, 8'hE0, 8'h10, 8'h00, 8'h61, 8'hE0, 8'h10};
    logic [7:0] o;
    if1.pattern = 8'h0D; if1.len = 4'd2;
    if1.start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 4) if1.start = 1'b0;
      o = obs1();
      vectors++;
      if (o !== exp[c]) begin
        miscompares++;
        $display("FAIL back_to_back cyc k+%0d: got %h expected %h", c + 1, o, exp[c]);
      end
    end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr = 1'b1;
    if1.start = 1'b0; if1.stop = 1'b0; if1.pattern = '0; if1.len = '0; if1.repeat_en = 1'b0;
    if4.start = 1'b0; if4.stop = 1'b0; if4.pattern = '0; if4.len = '0; if4.repeat_en = 1'b0;

    test_reset();
    test_single_shot();
    test_divider();
    test_repeat_stop();
    test_len_default();
    test_clr_midrun();
    test_start_stop_priority();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
